// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared decode-stage types: issue FSM states, register index
//               width and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scoreboard_cnt.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_cnt
// Description : Saturating up/down pending-write counter for one register.
//               Flags a decrement that arrives while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_nonzero,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Simultaneous inc and dec cancel; both ends saturate.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_nonzero   = (r_cnt != '0);
    assign o_underflow = i_dec && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_scoreboard
// Description : Decode-stage issue controller: RAW scoreboard plus branch
//               freeze/flush. Optional macro SCOREBOARD_WB_BYPASS_EN lets a
//               same-cycle final writeback clear a source hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard
    import mips_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_branch,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    input  logic             br_resolve,
    input  logic             br_taken,
    output logic             stall,
    output logic             issue,
    output logic             flush,
    output logic             busy,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit c_WB_BYPASS = 1'b1;
`else
    localparam bit c_WB_BYPASS = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next;
    logic             r_flush;
    logic             w_flush_nxt;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_nz;
    logic [NREG-1:0]  w_uflow;

    logic             w_byp_rs, w_byp_rt;
    logic             w_haz_rs, w_haz_rt, w_dst_full;
    logic             w_stall, w_issue, w_inc_en;

    // A final outstanding write retiring this cycle is visible to the read.
    assign w_byp_rs = c_WB_BYPASS && wb_valid && (wb_reg == id_rs) && (w_cnt[id_rs] == C_CNT_ONE);
    assign w_byp_rt = c_WB_BYPASS && wb_valid && (wb_reg == id_rt) && (w_cnt[id_rt] == C_CNT_ONE);

    assign w_haz_rs   = (id_rs != REG_ZERO) && (w_cnt[id_rs] != '0) && !w_byp_rs;
    assign w_haz_rt   = (id_rt != REG_ZERO) && (w_cnt[id_rt] != '0) && !w_byp_rt;
    assign w_dst_full = id_regwrite && (id_dst != REG_ZERO) && (w_cnt[id_dst] == C_CNT_MAX);

    assign w_stall  = id_valid && (!rstn || w_haz_rs || (id_use_rt && w_haz_rt) ||
                                   (r_state != RUN) || w_dst_full);
    assign w_issue  = id_valid && !w_stall;
    assign w_inc_en = w_issue && id_regwrite;

    assign w_cnt[0]   = '0;
    assign w_nz[0]    = 1'b0;
    assign w_uflow[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        scoreboard_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rstn        (rstn),
            .i_inc       (w_inc_en && (id_dst == REG_W'(g))),
            .i_dec       (wb_valid && (wb_reg == REG_W'(g))),
            .o_cnt       (w_cnt[g]),
            .o_nonzero   (w_nz[g]),
            .o_underflow (w_uflow[g])
        );
    end

    always_comb begin
        w_next      = r_state;
        w_flush_nxt = 1'b0;
        case (r_state)
            RUN: begin
                if (w_issue && id_branch) begin
                    w_next = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    w_next      = br_taken ? FLUSH : RUN;
                    w_flush_nxt = br_taken;
                end
            end
            FLUSH:   w_next = RUN;
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RUN;
            r_flush <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_flush <= w_flush_nxt;
            r_err   <= r_err | (|w_uflow);
        end
    end

    assign stall         = w_stall;
    assign issue         = w_issue;
    assign flush         = r_flush;
    assign busy          = |w_nz;
    assign err_underflow = r_err;

endmodule
`default_nettype wire
